// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage constants: bubble encoding, FSM state codes, reset PC.
// Also provides the word-alignment helper used on redirect targets.
package instruction_fetch_unit_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC  = 32'h0000_0000;
  localparam word_t NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [0:0] ST_FETCH  = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  function automatic word_t word_align(input word_t addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_plus4_adder.sv
// Sequential-PC incrementer: pure combinational 32-bit +4.
// The add wraps modulo 2^32, so 32'hFFFF_FFFC steps to 0.
module pc_plus4_adder (
  input  logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF-stage fetch engine: owns the PC, issues imem reads, applies redirects/stalls.
// Outputs are combinational (IF/ID captures them on the PC-advancing edge); IMEM_BUSYWAIT holds PC and the pipeline.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDRESS,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] OUT_INSTRUCTION,
  output logic [31:0] OUT_PC,
  output logic        BUSYWAIT
);

  logic [31:0] pc;
  logic [31:0] pending_target;
  logic [0:0]  state;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;
  logic        fetch_done;
  logic        emit_bubble;

  pc_plus4_adder u_pc_plus4_adder (
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  assign target_aligned = word_align(BRANCH_TARGET);
  assign fetch_done     = ~IMEM_BUSYWAIT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc             <= RESET_PC;
      pending_target <= 32'h0000_0000;
      state          <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          if (fetch_done) begin
            if (BRANCH_TAKEN)
              pc <= target_aligned;
            else if (!STALL)
              pc <= pc_plus4;
          end else if (BRANCH_TAKEN) begin
            // Read already in flight: park the target until memory finishes.
            pending_target <= target_aligned;
            state          <= ST_SQUASH;
          end
        end
        default: begin
          // A redirect arriving in the completion cycle is newer than the parked one.
          if (fetch_done) begin
            pc    <= BRANCH_TAKEN ? target_aligned : pending_target;
            state <= ST_FETCH;
          end else if (BRANCH_TAKEN) begin
            pending_target <= target_aligned;
          end
        end
      endcase
    end
  end

  assign emit_bubble = ~RESET | IMEM_BUSYWAIT | BRANCH_TAKEN | (state == ST_SQUASH);

  assign IMEM_READ       = RESET;
  assign IMEM_ADDRESS    = pc;
  assign OUT_PC          = pc;
  assign OUT_INSTRUCTION = emit_bubble ? NOP_INSTR : IMEM_READDATA;
  assign BUSYWAIT        = RESET & IMEM_BUSYWAIT;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a per-cycle vector table plus reset-corner sequences.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int NV = 25;

  logic        CLK;
  logic        RESET;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] IMEM_ADDRESS;
  logic        IMEM_READ;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;
  logic [31:0] OUT_INSTRUCTION;
  logic [31:0] OUT_PC;
  logic        BUSYWAIT;

  int n_vec;
  int n_fail;

  instruction_fetch_unit dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .STALL           (STALL),
    .BRANCH_TAKEN    (BRANCH_TAKEN),
    .BRANCH_TARGET   (BRANCH_TARGET),
    .IMEM_ADDRESS    (IMEM_ADDRESS),
    .IMEM_READ       (IMEM_READ),
    .IMEM_READDATA   (IMEM_READDATA),
    .IMEM_BUSYWAIT   (IMEM_BUSYWAIT),
    .OUT_INSTRUCTION (OUT_INSTRUCTION),
    .OUT_PC          (OUT_PC),
    .BUSYWAIT        (BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        ebw;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                              input logic [31:0] tgt, input logic busy,
                              input logic [31:0] rdata, input logic [31:0] epc,
                              input logic [31:0] einstr, input logic ebw);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt; v.busy = busy;
    v.rdata = rdata; v.epc = epc; v.einstr = einstr; v.ebw = ebw;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] epc,
                       input logic [31:0] einstr, input logic ebw, input logic erd);
    n_vec++;
    if (OUT_PC !== epc || IMEM_ADDRESS !== epc || OUT_INSTRUCTION !== einstr ||
        BUSYWAIT !== ebw || IMEM_READ !== erd) begin
      n_fail++;
      $display("FAIL %s: got pc=%h addr=%h instr=%h bw=%b rd=%b, want pc=%h instr=%h bw=%b rd=%b",
               name, OUT_PC, IMEM_ADDRESS, OUT_INSTRUCTION, BUSYWAIT, IMEM_READ,
               epc, einstr, ebw, erd);
    end
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;

    //            rst stall br  tgt           busy rdata          exp_pc        exp_instr      exp_bw
    vecs[0]  = mk(1, 0, 0, 32'h0,         0, 32'hC000_0000, 32'h0000_0000, 32'hC000_0000, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,         0, 32'hC000_0004, 32'h0000_0004, 32'hC000_0004, 0);
    vecs[2]  = mk(1, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, 32'h0000_0008, NOP,           1);
    vecs[3]  = mk(1, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, 32'h0000_0008, NOP,           1);
    vecs[4]  = mk(1, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, 32'h0000_0008, NOP,           1);
    vecs[5]  = mk(1, 0, 0, 32'h0,         0, 32'hC000_0008, 32'h0000_0008, 32'hC000_0008, 0);
    vecs[6]  = mk(1, 0, 0, 32'h0,         0, 32'hC000_000C, 32'h0000_000C, 32'hC000_000C, 0);
    vecs[7]  = mk(1, 1, 0, 32'h0,         0, 32'hC000_0010, 32'h0000_0010, 32'hC000_0010, 0);
    vecs[8]  = mk(1, 1, 0, 32'h0,         0, 32'hC000_0010, 32'h0000_0010, 32'hC000_0010, 0);
    vecs[9]  = mk(1, 0, 0, 32'h0,         0, 32'hC000_0010, 32'h0000_0010, 32'hC000_0010, 0);
    // idle-memory redirect at PC=20
    vecs[10] = mk(1, 0, 1, 32'h100,       0, 32'hC000_0014, 32'h0000_0014, NOP,           0);
    vecs[11] = mk(1, 0, 0, 32'h0,         0, 32'hC000_0100, 32'h0000_0100, 32'hC000_0100, 0);
    // busy-memory redirect, then a newer one while squashing
    vecs[12] = mk(1, 0, 1, 32'h200,       1, 32'hDEAD_BEEF, 32'h0000_0104, NOP,           1);
    vecs[13] = mk(1, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, 32'h0000_0104, NOP,           1);
    vecs[14] = mk(1, 0, 1, 32'h300,       1, 32'hDEAD_BEEF, 32'h0000_0104, NOP,           1);
    vecs[15] = mk(1, 0, 0, 32'h0,         0, 32'hC000_0104, 32'h0000_0104, NOP,           0);
    vecs[16] = mk(1, 0, 0, 32'h0,         0, 32'hC000_0300, 32'h0000_0300, 32'hC000_0300, 0);
    // misaligned target is forced to a word boundary
    vecs[17] = mk(1, 0, 1, 32'h103,       0, 32'hC000_0304, 32'h0000_0304, NOP,           0);
    vecs[18] = mk(1, 0, 0, 32'h0,         0, 32'hC000_0100, 32'h0000_0100, 32'hC000_0100, 0);
    // redirect during a stall is taken
    vecs[19] = mk(1, 1, 1, 32'hFFFF_FFFC, 0, 32'hC000_0104, 32'h0000_0104, NOP,           0);
    vecs[20] = mk(1, 0, 0, 32'h0,         0, 32'hCFFF_FFFC, 32'hFFFF_FFFC, 32'hCFFF_FFFC, 0);
    vecs[21] = mk(1, 0, 0, 32'h0,         0, 32'hC000_0000, 32'h0000_0000, 32'hC000_0000, 0);
    // redirect in the squash completion cycle overrides the parked target
    vecs[22] = mk(1, 0, 1, 32'h40,        1, 32'hDEAD_BEEF, 32'h0000_0004, NOP,           1);
    vecs[23] = mk(1, 0, 1, 32'h80,        0, 32'hC000_0004, 32'h0000_0004, NOP,           0);
    vecs[24] = mk(1, 0, 0, 32'h0,         0, 32'hC000_0080, 32'h0000_0080, 32'hC000_0080, 0);

    // asynchronous reset with no clock edge yet
    RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
    IMEM_BUSYWAIT = 1'b1; IMEM_READDATA = 32'hDEAD_BEEF;
    #1 RESET = 1'b0;
    #1 check("reset_async", 32'h0, NOP, 1'b0, 1'b0);

    @(negedge CLK);
    for (int i = 0; i < NV; i++) begin
      RESET         = vecs[i].rst;
      STALL         = vecs[i].stall;
      BRANCH_TAKEN  = vecs[i].br;
      BRANCH_TARGET = vecs[i].tgt;
      IMEM_BUSYWAIT = vecs[i].busy;
      IMEM_READDATA = vecs[i].rdata;
      #1 check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].einstr, vecs[i].ebw, vecs[i].rst);
      @(negedge CLK);
    end

    // reset pulse while a redirect is parked in SQUASH
    STALL = 1'b0; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h500;
    IMEM_BUSYWAIT = 1'b1; IMEM_READDATA = 32'hDEAD_BEEF;
    #1 check("squash_entry", 32'h84, NOP, 1'b1, 1'b1);
    @(posedge CLK);
    #1 BRANCH_TAKEN = 1'b0;
    #2 RESET = 1'b0;
    #1 check("reset_in_squash", 32'h0, NOP, 1'b0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1; IMEM_BUSYWAIT = 1'b0; IMEM_READDATA = 32'hC000_0000;
    #1 check("post_reset_fetch", 32'h0, 32'hC000_0000, 1'b0, 1'b1);
    @(posedge CLK);
    #1 check("post_reset_advance", 32'h4, 32'hC000_0000, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

IF-stage fetch engine of the RV32IM pipeline. Holds the program counter and drives the instruction-memory read handshake. Applies branch/jump redirects from EX and hazard-unit stalls, and presents the fetched instruction and its PC to the IF/ID pipeline register. Its BUSYWAIT output is the IF/ID register's write-hold.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble (addi x0,x0,0) presented when no valid instruction is available.

- CLK  in  1  pipeline clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low; clears all state immediately.
- STALL  in  1  hazard-unit stall; holds PC, re-fetches same address.
- BRANCH_TAKEN  in  1  one-cycle redirect pulse from EX.
- BRANCH_TARGET  in  32  redirect address; bits [1:0] ignored (forced 00).
- IMEM_ADDRESS  out  32  read address (= PC, or pending target after squash).
- IMEM_READ  out  1  read request.
- IMEM_READDATA  in  32  instruction word; valid when IMEM_READ=1 and IMEM_BUSYWAIT=0.
- IMEM_BUSYWAIT  in  1  memory not ready.
- OUT_INSTRUCTION  out  32  to IF/ID IN_INSTRUCTION.
- OUT_PC  out  32  to IF/ID IN_PC.
- BUSYWAIT  out  1  to IF/ID BUSYWAIT; pipeline hold.

## Operation
- State: PC register (32), PENDING_TARGET register (32), FSM {FETCH, SQUASH}.
- IMEM_READ=1 in every non-reset cycle; IMEM_ADDRESS=PC.
- Fetch completes in any cycle with IMEM_BUSYWAIT=0.
- FETCH, completing, no redirect:
  - OUT_INSTRUCTION=IMEM_READDATA, OUT_PC=PC.
  - At edge: PC<=PC+4 unless STALL=1 (PC held, same word re-fetched next cycle).
- FETCH, BRANCH_TAKEN=1, IMEM_BUSYWAIT=0:
  - OUT_INSTRUCTION=NOP_INSTR; the fetched word is squashed.
  - At edge: PC<=BRANCH_TARGET&~3.
- FETCH, BRANCH_TAKEN=1, IMEM_BUSYWAIT=1:
  - PENDING_TARGET<=BRANCH_TARGET&~3; FSM->SQUASH.
  - PC unchanged; the in-flight read must finish first.
- SQUASH:
  - OUT_INSTRUCTION=NOP_INSTR every cycle.
  - On completion edge: PC<=PENDING_TARGET, FSM->FETCH.
  - A further BRANCH_TAKEN in SQUASH overwrites PENDING_TARGET (latest redirect wins).
- Whenever IMEM_BUSYWAIT=1: OUT_INSTRUCTION=NOP_INSTR.
- BUSYWAIT=IMEM_BUSYWAIT.
- Priority: RESET > BRANCH_TAKEN > STALL > PC+4. A redirect in a STALL cycle is taken, not dropped.
- Arithmetic: PC+4 is a 32-bit add; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset (RESET=0, async):
  - PC=RESET_PC, FSM=FETCH, PENDING_TARGET=0.
  - OUT_PC=RESET_PC, OUT_INSTRUCTION=NOP_INSTR, IMEM_READ=0, BUSYWAIT=0 while asserted.
- Reset asserted mid-fetch or mid-SQUASH: everything above is applied immediately, and the pending redirect is discarded. The first read after deassertion is at RESET_PC.
- OUT_* and BUSYWAIT are combinational from state and memory inputs, so IF/ID captures them on the same posedge that advances PC.
- Zero-wait memory gives 1 instruction/cycle. An N-cycle busywait adds N cycles.
- Redirect costs 1 bubble with an idle memory. With a busy memory it costs (remaining busy cycles + 1) bubbles.

## Structure
- Shared macros/constants file (utils): NOP encoding, FSM state encodings, PC reset value.
- One sub-module, pc_plus4_adder (32-bit +4, wrapping).
- Everything else lives in instruction_fetch_unit.

## Test plan
- Reset: RESET=0 at t=1 with no clock edge → OUT_PC=0, OUT_INSTRUCTION=32'h13. Release RESET, zero-wait memory → OUT_PC sequence 0,4,8,12 on successive edges.
- Busywait: IMEM_BUSYWAIT=1 for 3 cycles at PC=8 → PC stays 8, BUSYWAIT=1, OUT_INSTRUCTION=NOP for 3 cycles. Word at 8 appears on the 4th cycle, then PC=12.
- Stall: STALL=1 for 2 cycles at PC=16 → OUT_PC=16 for 3 cycles, then 20.
- Redirect, idle memory: BRANCH_TAKEN=1, BRANCH_TARGET=32'h100 at PC=20 → that cycle outputs NOP. Next OUT_PC=32'h100.
- Redirect, busy memory: BRANCH_TAKEN=1, target 32'h200 while busywait=1 for 2 more cycles → NOP output through completion, then OUT_PC=32'h200. A second redirect to 32'h300 during SQUASH → 32'h300 wins.
- Edge cases:
  - RESET pulsed during SQUASH → next fetch at 0.
  - PC=32'hFFFF_FFFC advances to 0.
  - BRANCH_TARGET=32'h103 → fetch at 32'h100.
  - Redirect with STALL=1 → redirect taken.
